rs_issue_scheduler: RTL
=======================

# rs_issue_scheduler

Reservation-station controller sitting between the dispatch stage and one functional unit. It buffers up to RS_ENTRIES renamed instructions and tracks source-operand readiness through CDB tag wakeup. Each cycle it selects the oldest fully-ready entry and issues it to the FU under a valid/ready handshake. One instance is built per FU (NUM_FUS instances in the core).

## Interface
Parameters:
- RS_ENTRIES, 4, number of station entries
- NUM_PREGS, 64, physical registers; tag width PW = $clog2(NUM_PREGS)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all entries (branch mispredict recovery)
- disp_valid  in  1  dispatch packet offered
- disp_ready  out  1  station can accept a packet this cycle
- disp_pkt  in  disp_packet_t  renamed instruction
- disp_src1_rdy  in  1  src1_preg already ready (busy-table lookup)
- disp_src2_rdy  in  1  src2_preg already ready
- cdb_valid  in  1  completion broadcast valid
- cdb_preg  in  PW  physical tag being written back
- issue_valid  out  1  issue_pkt holds a ready instruction
- issue_ready  in  1  FU accepts this cycle
- issue_pkt  out  disp_packet_t  selected instruction
- occupancy  out  $clog2(RS_ENTRIES)+1  valid entry count

## Operation
- Per-entry state: valid, pkt, src1_rdy, src2_rdy, age ($clog2(RS_ENTRIES) bits).
- Dispatch fire = disp_valid && disp_ready && !flush. The packet is written into the lowest-index free entry. Its age is set to 0. Every other valid entry's age increments, saturating at RS_ENTRIES-1.
- The age ordering is strict: no two valid entries ever share an age.
- disp_ready = !full, driven from registered state only. It has no combinational path from issue_ready.
- Wakeup: when cdb_valid is high, every valid entry whose src1_preg or src2_preg equals cdb_preg sets the matching rdy bit.
- Dispatch bypass: an incoming packet whose src tag equals cdb_preg with cdb_valid high is written with that rdy bit set.
- Select: the candidate set is valid && src1_rdy && src2_rdy. The candidate with the largest age wins.
  - issue_valid = candidate set non-empty.
  - issue_pkt = the winner's pkt; all-zero when issue_valid is low.
- Issue fire = issue_valid && issue_ready. The winning entry is cleared at the edge. issue_pkt must hold stable while issue_valid is high and issue_ready is low, unless an older entry becomes ready.
- Simultaneous issue fire and dispatch fire: both take effect. When full, disp_ready is still 0 that cycle, so there is no same-cycle reuse of the freed slot.
- Flush: all valid bits are cleared at the edge. Any dispatch in the same cycle is dropped. issue_valid still reflects pre-flush state in the flush cycle.
- occupancy = popcount(valid).

## Timing
- Reset: all entries invalid, ages 0, issue_valid=0, issue_pkt=0, disp_ready=1, occupancy=0.
- Reset mid-operation discards all entries identically to flush, and overrides dispatch and issue.
- Latency, dispatch to earliest issue: an entry dispatched with both sources ready at edge N is eligible for issue_valid in cycle N (visible after edge N), i.e. a one-cycle minimum residency.
- Wakeup to issue: a CDB broadcast in cycle N makes the entry issuable in cycle N+1. There is no same-cycle CDB to issue path.
- Select is combinational from registered state. issue_pkt is a mux output with no extra register.

## Structure
- Add to CORE_PKG:
  - rs_entry_t: packed struct of valid, disp_packet_t pkt, src1_rdy, src2_rdy, age.
  - RS_AGE_W = $clog2(RS_ENTRIES).
- Sub-module rs_age_select: purely combinational. Inputs are the ready mask and the age vectors. Outputs are a one-hot grant and grant_valid. Written reusable for a future load/store queue select.

## Test plan
- Reset, then dispatch one packet (src1_preg=5, src2_preg=6, both rdy) with issue_ready=1 -> issue_valid=1 next cycle with pc matching, occupancy goes 1 then 0.
- Fill 4 entries with src1 not ready (tag 9) -> disp_ready=0, occupancy=4, issue_valid=0. Drive cdb_preg=9 -> all ready next cycle; the first-dispatched entry issues first and the rest issue in dispatch order.
- Dispatch with src2_preg=12 while cdb_valid=1, cdb_preg=12 in the same cycle -> entry issues the next cycle (bypass honored).
- Hold issue_ready=0 for 3 cycles with one ready entry -> issue_valid and issue_pkt stay stable; the entry is freed only on the cycle issue_ready=1.
- Three entries valid, assert flush together with disp_valid=1 -> occupancy=0 and issue_valid=0 next cycle, and the dispatched packet never issues.
- Saturation and wrap: run 20 random dispatch/issue cycles with interleaved CDB tags -> the scoreboard model confirms oldest-ready order, no lost or duplicated packets, and no dispatch accepted while full.

Source files
------------

// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types for the reservation-station issue scheduler:
// dispatch packet, station entry and sizing constants.
package rs_issue_scheduler_pkg;

    localparam int CORE_NUM_PREGS  = 64;
    localparam int PREG_W          = $clog2(CORE_NUM_PREGS);
    localparam int CORE_RS_ENTRIES = 4;
    localparam int RS_AGE_W        = $clog2(CORE_RS_ENTRIES);

    typedef logic [PREG_W-1:0] preg_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  uop;
        preg_t       dst_preg;
        preg_t       src1_preg;
        preg_t       src2_preg;
    } disp_packet_t;

    typedef struct packed {
        logic                valid;
        disp_packet_t        pkt;
        logic                src1_rdy;
        logic                src2_rdy;
        logic [RS_AGE_W-1:0] age;
    } rs_entry_t;

    function automatic logic tag_hit(
        input logic  bcast_valid,
        input preg_t bcast_tag,
        input preg_t src_tag
    );
        return bcast_valid && (bcast_tag == src_tag);
    endfunction

endpackage

// File: rtl/rs_issue_scheduler_age_select.sv
// Oldest-first picker: grants the requester with the largest age.
// Shared by any age-ordered queue (RS, future LSQ).
module rs_age_select #(
    parameter int N  = 4,
    parameter int AW = 2
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0][AW-1:0] age,
    output logic [N-1:0]         grant,
    output logic                 grant_valid
);

    logic [AW-1:0] best_age;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        best_age    = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (!grant_valid || age[i] > best_age)) begin
                grant       = '0;
                grant[i]    = 1'b1;
                grant_valid = 1'b1;
                best_age    = age[i];
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation station: buffers renamed ops, wakes sources on CDB
// broadcasts and issues the oldest ready op to one functional unit.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
#(
    parameter int RS_ENTRIES = CORE_RS_ENTRIES,
    parameter int NUM_PREGS  = CORE_NUM_PREGS,
    localparam int PW        = $clog2(NUM_PREGS),
    localparam int OW        = $clog2(RS_ENTRIES) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         disp_valid,
    output logic         disp_ready,
    input  disp_packet_t disp_pkt,
    input  logic         disp_src1_rdy,
    input  logic         disp_src2_rdy,
    input  logic         cdb_valid,
    input  logic [PW-1:0] cdb_preg,
    output logic         issue_valid,
    input  logic         issue_ready,
    output disp_packet_t issue_pkt,
    output logic [OW-1:0] occupancy
);

    localparam logic [RS_AGE_W-1:0] AGE_MAX = RS_AGE_W'(RS_ENTRIES - 1);
    localparam logic [RS_AGE_W-1:0] AGE_ONE = RS_AGE_W'(1);

    rs_entry_t [RS_ENTRIES-1:0] entries_q;
    rs_entry_t [RS_ENTRIES-1:0] entries_d;

    logic [RS_ENTRIES-1:0]               ready_vec;
    logic [RS_ENTRIES-1:0]               free_oh;
    logic [RS_ENTRIES-1:0]               grant;
    logic [RS_ENTRIES-1:0][RS_AGE_W-1:0] age_vec;
    logic                                grant_valid;
    logic                                full;
    logic                                disp_fire;
    logic                                issue_fire;
    logic [RS_AGE_W-1:0]                 win_age;
    logic [OW-1:0]                       occ;
    rs_entry_t                           new_entry;

    always_comb begin
        occ       = '0;
        free_oh   = '0;
        ready_vec = '0;
        age_vec   = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            ready_vec[i] = entries_q[i].valid && entries_q[i].src1_rdy
                           && entries_q[i].src2_rdy;
            age_vec[i]   = entries_q[i].age;
            occ          = occ + OW'(entries_q[i].valid);
            if (!entries_q[i].valid && (free_oh == '0)) begin
                free_oh[i] = 1'b1;
            end
        end
    end

    assign full       = (occ == OW'(RS_ENTRIES));
    assign disp_ready = !full;
    assign occupancy  = occ;
    assign disp_fire  = disp_valid && !full && !flush;

    rs_age_select #(
        .N  (RS_ENTRIES),
        .AW (RS_AGE_W)
    ) u_select (
        .req         (ready_vec),
        .age         (age_vec),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign issue_valid = grant_valid;
    assign issue_fire  = grant_valid && issue_ready;

    always_comb begin
        issue_pkt = '0;
        win_age   = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (grant[i]) begin
                issue_pkt = entries_q[i].pkt;
                win_age   = entries_q[i].age;
            end
        end
    end

    always_comb begin
        new_entry          = '0;
        new_entry.valid    = 1'b1;
        new_entry.pkt      = disp_pkt;
        new_entry.src1_rdy = disp_src1_rdy
                             || tag_hit(cdb_valid, cdb_preg, disp_pkt.src1_preg);
        new_entry.src2_rdy = disp_src2_rdy
                             || tag_hit(cdb_valid, cdb_preg, disp_pkt.src2_preg);
    end

    // Entries older than the issued one close the gap, so ages stay a
    // dense 0..occ-1 ranking and the dispatch increment never collides.
    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (entries_q[i].valid) begin
                if (tag_hit(cdb_valid, cdb_preg, entries_q[i].pkt.src1_preg)) begin
                    entries_d[i].src1_rdy = 1'b1;
                end
                if (tag_hit(cdb_valid, cdb_preg, entries_q[i].pkt.src2_preg)) begin
                    entries_d[i].src2_rdy = 1'b1;
                end
                if (issue_fire && (entries_q[i].age > win_age)) begin
                    entries_d[i].age = entries_q[i].age - AGE_ONE;
                end
                if (disp_fire && (entries_d[i].age != AGE_MAX)) begin
                    entries_d[i].age = entries_d[i].age + AGE_ONE;
                end
            end
            if (issue_fire && grant[i]) begin
                entries_d[i] = '0;
            end
            if (disp_fire && free_oh[i]) begin
                entries_d[i] = new_entry;
            end
            if (flush) begin
                entries_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule
